// File: rtl/raman_pkg.sv
// Shared constants, state encoding and word-formatting helpers for the
// Raman ratio streaming path.
package raman_pkg;

  // Width of one ratio sample produced by the divider pool
  localparam int SAMPLE_W    = 12;
  // Width of one word on the host stream
  localparam int WORD_W      = 16;
  // Width of the rolling frame counter carried in the header
  localparam int FRAME_CNT_W = 12;
  // Header tag occupies whatever the frame counter leaves free
  localparam int TAG_W       = WORD_W - FRAME_CNT_W;

  // Default upper nibble of the header word
  localparam logic [TAG_W-1:0] DEF_HDR_TAG = 4'hA;

  // Streamer states; ST_CSUM is only reachable when the checksum is built in
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR,
    ST_DATA,
    ST_CSUM
  } state_t;

  // Zero-extend a ratio sample into a stream word
  function automatic logic [WORD_W-1:0] sample_word(input logic [SAMPLE_W-1:0] s);
    return {{(WORD_W - SAMPLE_W){1'b0}}, s};
  endfunction

  // Build the frame header from its tag and the rolling frame count
  function automatic logic [WORD_W-1:0] header_word(input logic [TAG_W-1:0]       tag,
                                                    input logic [FRAME_CNT_W-1:0] cnt);
    return {tag, cnt};
  endfunction

endpackage

// File: rtl/stream_checksum.sv
// Running modulo-2^16 sum of the DATA words of one frame. The sum output
// already includes the word being accepted this cycle, so the streamer can
// register the final checksum on the same edge that accepts the last sample.
module stream_checksum
  import raman_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              add_en,
  input  logic [WORD_W-1:0] add_data,
  output logic [WORD_W-1:0] sum
);

  logic [WORD_W-1:0] acc_q;

  // Look-ahead sum: accumulator plus the word accepted in this cycle
  assign sum = add_en ? (acc_q + add_data) : acc_q;

  // Accumulator register, cleared at the start of every frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (clear) begin
      acc_q <= '0;
    end else begin
      acc_q <= sum;
    end
  end

endmodule

// File: rtl/ratio_stream_out.sv
// Consumer-side reader of the Stokes/anti-Stokes ratio pool. On the falling
// edge of div_en it snapshots the packed ratio vector and streams it as a
// framed sequence of 16-bit words (header, samples, optional checksum) over
// a valid/ready interface, so the pool may overwrite its store while a slow
// host drains the previous frame.
//
// Build option: define RATIO_STREAM_CHECKSUM_EN to append a checksum word
// (modulo-2^16 sum of the sample words) after the last sample.
module ratio_stream_out
  import raman_pkg::*;
#(
  parameter int               POINTS  = 16,
  parameter logic [TAG_W-1:0] HDR_TAG = DEF_HDR_TAG
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [SAMPLE_W*POINTS-1:0] store,
  input  logic                       div_en,
  output logic [WORD_W-1:0]          out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_last,
  output logic                       busy,
  output logic                       overrun,
  output logic [7:0]                 drop_cnt
);

  // Index width kept at least one bit so POINTS == 1 still elaborates
  localparam int              IDX_W    = (POINTS > 1) ? $clog2(POINTS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(POINTS - 1);

  state_t                     state_q;
  state_t                     state_d;
  logic [IDX_W-1:0]           idx_q;
  logic [IDX_W-1:0]           idx_d;
  logic                       div_en_q;
  logic                       trigger;
  logic                       start;
  logic                       drop;
  logic                       hs;
  logic                       frame_done;
  logic [FRAME_CNT_W-1:0]     frame_cnt;
  logic [SAMPLE_W*POINTS-1:0] snapshot;
  logic [SAMPLE_W-1:0]        points [POINTS];
  logic [WORD_W-1:0]          out_data_d;
  logic                       out_valid_d;
  logic                       out_last_d;

  // ---------------------------------------------------------------------
  // Trigger detection and frame accept/drop decision
  // ---------------------------------------------------------------------

  // Delay div_en by one cycle to find the end of a division pass
  // NOTE: sequential state is always assigned with <= so every flop samples
  // the pre-edge values of its inputs regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_en_q <= 1'b0;
    end else begin
      div_en_q <= div_en;
    end
  end

  assign trigger    = div_en_q & ~div_en;
  // A frame is only accepted from IDLE; in the cycle that accepts the last
  // word the streamer is still busy, so a coinciding trigger is dropped.
  assign start      = trigger & (state_q == ST_IDLE);
  assign drop       = trigger & (state_q != ST_IDLE);
  assign hs         = out_valid & out_ready;
  assign frame_done = hs & out_last;

  // ---------------------------------------------------------------------
  // Snapshot register and sample mux
  // ---------------------------------------------------------------------

  // Capture the pool's store when a new frame is accepted
  // NOTE: the snapshot is a pure data store with no reset; it is only read
  // in DATA, which cannot be reached without first loading it.
  always_ff @(posedge clk) begin
    if (start) begin
      snapshot <= store;
    end
  end

  // Point 0 sits in the most significant slice of the packed vector
  for (genvar k = 0; k < POINTS; k++) begin : g_unpack
    assign points[k] = snapshot[SAMPLE_W*(POINTS-k)-1 -: SAMPLE_W];
  end

  // ---------------------------------------------------------------------
  // Optional checksum accumulator
  // ---------------------------------------------------------------------
`ifdef RATIO_STREAM_CHECKSUM_EN
  logic [WORD_W-1:0] csum;

  stream_checksum u_csum (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (start),
    .add_en   (hs && (state_q == ST_DATA)),
    .add_data (out_data),
    .sum      (csum)
  );
`endif

  // ---------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------

  // State and sample index register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state logic: every state except IDLE advances only on handshake
  // NOTE: each combinational output gets a default before the case so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_HDR;
          idx_d   = '0;
        end
      end
      ST_HDR: begin
        if (hs) begin
          state_d = ST_DATA;
          idx_d   = '0;
        end
      end
      ST_DATA: begin
        if (hs) begin
          if (idx_q == IDX_LAST) begin
`ifdef RATIO_STREAM_CHECKSUM_EN
            state_d = ST_CSUM;
`else
            state_d = ST_IDLE;
`endif
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
`ifdef RATIO_STREAM_CHECKSUM_EN
      ST_CSUM: begin
        if (hs) begin
          state_d = ST_IDLE;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output logic: next-cycle word derived from the state being entered, so
  // the stream outputs can be registered without adding latency. While a
  // word is stalled, state and index hold, and so does the recomputed word.
  always_comb begin
    out_valid_d = (state_d != ST_IDLE);
    out_last_d  = 1'b0;
    out_data_d  = '0;
    case (state_d)
      ST_HDR: begin
        out_data_d = header_word(HDR_TAG, frame_cnt);
      end
      ST_DATA: begin
        out_data_d = sample_word(points[idx_d]);
`ifndef RATIO_STREAM_CHECKSUM_EN
        out_last_d = (idx_d == IDX_LAST);
`endif
      end
`ifdef RATIO_STREAM_CHECKSUM_EN
      ST_CSUM: begin
        out_data_d = csum;
        out_last_d = 1'b1;
      end
`endif
      default: begin
        out_data_d = '0;
      end
    endcase
  end

  // Registered stream outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      out_data  <= out_data_d;
      out_valid <= out_valid_d;
      out_last  <= out_last_d;
      busy      <= (state_d != ST_IDLE);
    end
  end

  // ---------------------------------------------------------------------
  // Frame bookkeeping
  // ---------------------------------------------------------------------

  // Rolling frame counter, advanced when the last word of a frame is taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
    end else if (frame_done) begin
      frame_cnt <= frame_cnt + 1'b1;
    end
  end

  // Sticky overrun flag and saturating count of dropped frames
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun  <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overrun <= 1'b1;
      if (drop_cnt != 8'hFF) begin
        drop_cnt <= drop_cnt + 1'b1;
      end
    end
  end

endmodule

// File: doc/ratio_stream_out.md
# ratio_stream_out

Reader on the consumer side of the Stokes/anti-Stokes ratio pool. When a division pass finishes, it snapshots the packed vector of 12-bit ratios and streams it as a framed sequence of 16-bit words over a valid/ready interface toward the host link (UART/USB bridge). It decouples the pool, which overwrites its store every measurement cycle, from a host that may stall.

## Interface
- `POINTS`, default 16: number of 12-bit ratio samples per frame; must be at least 1.
- `HDR_TAG`, default 4'hA: upper nibble of the header word.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `store`  in  12*POINTS  packed ratios from the pool. Point k occupies bits `[12*(POINTS-k)-1 -: 12]`, so point 0 is the most significant slice.
- `div_en`  in  1  pool division-active flag. A falling edge means `store` is complete.
- `out_data`  out  16  stream word.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  downstream accepts the word.
- `out_last`  out  1  marks the final word of a frame.
- `busy`  out  1  a frame is being streamed.
- `overrun`  out  1  sticky: a frame was dropped. Cleared only by reset.
- `drop_cnt`  out  8  count of dropped frames, saturating at 255.

## Operation
- Trigger: `div_en_q & ~div_en`, where `div_en_q` is `div_en` registered.
- Trigger while IDLE:
  - latch `store` into the snapshot register;
  - clear `idx`;
  - go to HDR.
- Trigger while not IDLE:
  - the frame is dropped and the snapshot is untouched;
  - set `overrun`;
  - increment `drop_cnt`, saturating.
- States: IDLE → HDR → DATA → (CSUM) → IDLE.
  - HDR: `out_data = {HDR_TAG, frame_cnt[11:0]}`.
  - DATA: `out_data = {4'h0, snapshot point idx}`, with `idx` running 0..POINTS-1.
  - A state advances only on handshake (`out_valid & out_ready`).
  - DATA stays in DATA until the word at `idx == POINTS-1` is accepted.
- Frame end: on acceptance of the frame's last word, `frame_cnt` increments, wrapping 4095 → 0.
- `busy` is 1 in every state except IDLE.
- Trigger coinciding with acceptance of the last word: still counts as busy. The frame is dropped and flagged.
- Checksum: 16-bit modulo-2^16 sum of all DATA words, excluding the header. Cleared on entry to HDR.
- Reset mid-frame: the frame is abandoned with no `out_last`, and `frame_cnt` returns to 0.

## Timing
- Reset values are all 0: `out_data`, `out_valid`, `out_last`, `busy`, `overrun`, `drop_cnt`, `frame_cnt`, state = IDLE.
- All outputs are registered.
- Trigger latency:
  - `div_en` sampled low at edge N after being high at N-1 → trigger at edge N.
  - Snapshot taken at edge N.
  - `out_valid = 1` with the header from edge N+1.
- While `out_valid & ~out_ready`, `out_data` and `out_last` hold stable.
- Throughput: one word per cycle with `out_ready` held high.
  - Frame length is POINTS+1 words, or POINTS+2 with CSUM.
  - `out_valid` deasserts in the cycle after the last handshake unless a new frame has already started. A new frame cannot start in that cycle because of the busy rule.
- `out_last` is asserted only together with `out_valid`, on the final word.

## Configuration
- Macro: `RATIO_STREAM_CHECKSUM_EN`.
- Defined: CSUM state follows DATA and emits the checksum word. `out_last` goes on the CSUM word.
- Undefined: no CSUM state and no checksum adder. `out_last` goes on DATA word `idx == POINTS-1`.

## Structure
- `raman_pkg` holds:
  - `SAMPLE_W = 12`
  - `WORD_W = 16`
  - `FRAME_CNT_W = 12`
  - the default `HDR_TAG`
  - the state enum `{ST_IDLE, ST_HDR, ST_DATA, ST_CSUM}`
- The checksum accumulator is a natural sub-module, `stream_checksum`. It is instantiated only under the macro.
- The snapshot register and mux stay in the top module.

## Test plan
- Basic frame: POINTS=4, `store = {12'h001,12'h002,12'h003,12'h004}`, `div_en` 1→0, `out_ready = 1` → words 16'hA000, 0001, 0002, 0003, 0004.
  - `out_last` on 0004 without the macro.
  - With the macro, an extra word 000A carrying `out_last`.
- Backpressure: same frame, `out_ready` toggled 1,0,0,1,... → no word lost or duplicated, and `out_data` is stable during stalls.
- Overrun: second `div_en` falling edge during DATA → first frame completes unchanged, `overrun = 1`, `drop_cnt = 1`, no second frame.
- Snapshot isolation: `store` changed to all-ones after the trigger → streamed samples still 001..004.
- Reset mid-frame: `rst_n` low during DATA `idx = 2` → all outputs 0 immediately. The next trigger produces header 16'hA000.
- Counter wrap: 4097 consecutive frames → header of frame 4096 is 16'hAFFF, the next is 16'hA000. 300 drops → `drop_cnt = 255`.
